// File: rtl/bus_bridge_m_uart_endpoint_if.sv
// rtl/bus_bridge_m_uart_endpoint_if.sv - bus-B request/response channel between endpoint and bus
interface bus_bridge_m_uart_endpoint_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [15:0] bus_req_addr;
    logic [7:0]  bus_req_wdata;
    logic        bus_req_write;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [7:0]  bus_resp_rdata;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_wdata, bus_req_write, bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_wdata, bus_req_write, bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata
    );
endinterface

// File: rtl/bus_bridge_m_uart_endpoint.sv
// rtl/bus_bridge_m_uart_endpoint.sv - UART request deframer issuing bus-B transactions and framing responses
module bus_bridge_m_uart_endpoint #(
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_ready,
    output logic        uart_ready_clr,
    output logic [7:0]  uart_data_in,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    bus_bridge_m_uart_endpoint_if.master bus,
    output logic        frame_err,
    output logic        rx_overrun
);
    localparam int CW = (FRAME_TIMEOUT > 0) ? $clog2(FRAME_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(FRAME_TIMEOUT);

    typedef enum logic [3:0] {
        RX_ADDR_L, RX_ADDR_H, RX_DATA, RX_FLAGS, ISSUE, WAIT_RESP,
        TX_DATA, TX_DATA_WAIT, TX_FLAGS, TX_FLAGS_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic          ready_q, busy_q;
    logic [15:0]   req_addr;
    logic [7:0]    req_wdata;
    logic          req_write;
    logic [7:0]    resp_data;
    logic [CW-1:0] cnt;
    logic          rx_byte, tx_done, in_rx, counting, timeout, tx_start;

    assign rx_byte  = uart_ready && !ready_q;
    assign tx_done  = busy_q && !uart_tx_busy;
    assign in_rx    = (state == RX_ADDR_L) || counting;
    assign counting = (state == RX_ADDR_H) || (state == RX_DATA) || (state == RX_FLAGS);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout  = (FRAME_TIMEOUT != 0) && counting && !rx_byte && (cnt >= TO_VAL);
    assign tx_start = ((state == TX_DATA) || (state == TX_FLAGS)) && !uart_tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_ADDR_L;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_ADDR_L:     if (rx_byte) state_nxt = RX_ADDR_H;
            RX_ADDR_H:     if (rx_byte) state_nxt = RX_DATA;  else if (timeout) state_nxt = RX_ADDR_L;
            RX_DATA:       if (rx_byte) state_nxt = RX_FLAGS; else if (timeout) state_nxt = RX_ADDR_L;
            RX_FLAGS:      if (rx_byte) state_nxt = ISSUE;    else if (timeout) state_nxt = RX_ADDR_L;
            ISSUE:         if (bus.bus_req_ready) state_nxt = WAIT_RESP;
            WAIT_RESP:     if (bus.bus_resp_valid) state_nxt = TX_DATA;
            TX_DATA:       if (!uart_tx_busy) state_nxt = TX_DATA_WAIT;
            TX_DATA_WAIT:  if (tx_done) state_nxt = TX_FLAGS;
            TX_FLAGS:      if (!uart_tx_busy) state_nxt = TX_FLAGS_WAIT;
            TX_FLAGS_WAIT: if (tx_done) state_nxt = RX_ADDR_L;
            default:       state_nxt = RX_ADDR_L;
        endcase
    end

    always_comb begin
        bus.bus_req_valid  = (state == ISSUE);
        bus.bus_resp_ready = (state == WAIT_RESP);
        bus.bus_req_addr   = req_addr;
        bus.bus_req_wdata  = req_wdata;
        bus.bus_req_write  = req_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            req_addr       <= 16'h0000;
            req_wdata      <= 8'h00;
            req_write      <= 1'b0;
            resp_data      <= 8'h00;
            cnt            <= '0;
            uart_ready_clr <= 1'b0;
            rx_overrun     <= 1'b0;
            frame_err      <= 1'b0;
            uart_wr_en     <= 1'b0;
            uart_data_in   <= 8'h00;
        end else begin
            ready_q        <= uart_ready;
            busy_q         <= uart_tx_busy;
            uart_ready_clr <= rx_byte;
            rx_overrun     <= rx_byte && !in_rx;
            frame_err      <= timeout;
            uart_wr_en     <= tx_start;

            if (rx_byte || !counting) cnt <= '0;
            else if (cnt != '1)       cnt <= cnt + 1'b1;

            if (rx_byte) begin
                case (state)
                    RX_ADDR_L: req_addr[7:0]  <= uart_data_out;
                    RX_ADDR_H: req_addr[15:8] <= uart_data_out;
                    RX_DATA:   req_wdata      <= uart_data_out;
                    RX_FLAGS:  req_write      <= uart_data_out[0];
                    default:   ;
                endcase
            end

            if (state == WAIT_RESP && bus.bus_resp_valid)
                resp_data <= req_write ? 8'h00 : bus.bus_resp_rdata;

            if (tx_start)
                uart_data_in <= (state == TX_DATA) ? resp_data : {7'b0, req_write};
        end
    end
endmodule
